// File: rtl/toggle_event_receiver.sv
// toggle_event_receiver: synchronise a toggle line, detect level changes, queue them as pending events
module toggle_event_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              T_in,
  input  logic              En,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              pulse,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  evt_count,
  output logic              overflow,
  input  logic              clr_ovf
);
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam int IW = $clog2(SYNC_STAGES + 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [0:0] state_q, state_d;
  logic [IW-1:0] init_q, init_d;
  logic ref_q, ref_d, pulse_q, ovf_q, ovf_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic sync_out, fill_done, toggle, accept, pop, full;
  assign sync_out = sync_q[SYNC_STAGES-1];
  // reference is loaded only once the chain holds a real sample, so a level held through reset is not an event
  assign fill_done = (state_q == INIT) && (init_q == IW'(SYNC_STAGES));
  assign toggle = (state_q == RUN) && (sync_out != ref_q);
  assign accept = toggle && En;
  assign pop = evt_valid && evt_ready;
  assign full = &pend_q;
  always_comb begin
    state_d = fill_done ? RUN : state_q;
    init_d = (state_q == INIT) ? init_q + 1'b1 : init_q;
    ref_d = (fill_done || toggle) ? sync_out : ref_q;
    pend_d = (accept && !pop && !full) ? pend_q + 1'b1 : (!accept && pop) ? pend_q - 1'b1 : pend_q;
    ovf_d = (accept && !pop && full) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      state_q <= INIT;
      init_q <= '0;
      ref_q <= 1'b0;
      pulse_q <= 1'b0;
      pend_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], T_in};
      state_q <= state_d;
      init_q <= init_d;
      ref_q <= ref_d;
      pulse_q <= accept;
      pend_q <= pend_d;
      cnt_q <= accept ? cnt_q + 1'b1 : cnt_q;
      ovf_q <= ovf_d;
    end
  end
  assign evt_valid = (pend_q != '0);
  assign pulse = pulse_q;
  assign pending = pend_q;
  assign evt_count = cnt_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_toggle_event_receiver.sv
// tb_toggle_event_receiver: directed toggles with a pulse-driven scoreboard of expected count/pending
module tb_toggle_event_receiver;
  logic clk = 1'b0, rst = 1'b1, T_in = 1'b0, En = 1'b1, evt_ready = 1'b0, clr_ovf = 1'b0;
  logic evt_valid, pulse, overflow;
  logic [3:0] pending;
  logic [7:0] evt_count;
  int n_cmp = 0, n_err = 0;
  int exp_cnt[$], exp_pend[$];
  toggle_event_receiver dut (
    .clk(clk), .rst(rst), .T_in(T_in), .En(En), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .pulse(pulse), .pending(pending), .evt_count(evt_count), .overflow(overflow), .clr_ovf(clr_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_evt(input int c, input int p);
    exp_cnt.push_back(c);
    exp_pend.push_back(p);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);
  endtask
  task automatic toggle4();
    T_in = ~T_in;
    tick(4);
  endtask
  // monitor: every pulse must match the next queued expectation
  initial forever begin
    @(negedge clk);
    if (pulse === 1'b1) begin
      if (exp_cnt.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        chk("sb_evt_count", int'(evt_count), exp_cnt.pop_front());
        chk("sb_pending", int'(pending), exp_pend.pop_front());
      end
    end
  end
  initial begin
    T_in = 1'b1;
    do_reset();
    tick(5);
    chk("t1_pulse", pulse, 0);
    chk("t1_pending", pending, 0);
    chk("t1_count", evt_count, 0);
    chk("t1_valid", evt_valid, 0);
    T_in = 1'b0;
    do_reset();
    T_in = 1'b1;
    tick();
    chk("t2_lat_a", pulse, 0);
    tick();
    chk("t2_lat_b", pulse, 0);
    expect_evt(1, 1);
    tick();
    chk("t2_lat_c", pulse, 1);
    chk("t2_pending", pending, 1);
    chk("t2_valid", evt_valid, 1);
    chk("t2_count", evt_count, 1);
    tick();
    chk("t2_lat_d", pulse, 0);
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      expect_evt(i, (i > 15) ? 15 : i);
      toggle4();
    end
    chk("t3_pending", pending, 15);
    chk("t3_ovf", overflow, 1);
    chk("t3_count", evt_count, 16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_clr", overflow, 0);
    T_in = ~T_in;
    tick(2);
    evt_ready = 1'b1;
    expect_evt(17, 15);
    tick();
    evt_ready = 1'b0;
    chk("t4_pending", pending, 15);
    chk("t4_ovf", overflow, 0);
    chk("t4_count", evt_count, 17);
    do_reset();
    En = 1'b0;
    repeat (3) toggle4();
    En = 1'b1;
    expect_evt(1, 1);
    toggle4();
    chk("t5_count", evt_count, 1);
    chk("t5_pending", pending, 1);
    for (int i = 2; i <= 5; i++) begin
      expect_evt(i, i);
      toggle4();
    end
    chk("t6_pre", pending, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_pending", pending, 0);
    chk("t6_valid", evt_valid, 0);
    tick(5);
    expect_evt(1, 1);
    toggle4();
    chk("t6_count", evt_count, 1);
    do_reset();
    evt_ready = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      expect_evt(i % 256, 1);
      toggle4();
    end
    tick(3);
    chk("wrap_count", evt_count, 0);
    chk("drain_pending", pending, 0);
    chk("drain_valid", evt_valid, 0);
    chk("drain_ovf", overflow, 0);
    tick(4);
    chk("sb_leftover", exp_cnt.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
